// File: rtl/tag_lookup_ctrl_if.sv
// Lookup, fill and tag-write signals between the tag lookup controller and its
// surroundings. The controller side uses the master modport.
interface tag_lookup_ctrl_if #(
    parameter int NUM_WAYS = 4,
    parameter int INDEX_W  = 4
);
    localparam int WAY_W = $clog2(NUM_WAYS);

    logic                   req_valid;
    logic                   req_ready;
    logic [31:0]            req_addr;
    logic [INDEX_W-1:0]     rd_index;
    logic [4*NUM_WAYS-1:0]  halt_tags;
    logic [20*NUM_WAYS-1:0] main_tags;
    logic                   resp_valid;
    logic                   resp_hit;
    logic [WAY_W-1:0]       resp_way;
    logic                   fill_req;
    logic [31:0]            fill_addr;
    logic                   fill_ack;
    logic                   regWrite;
    logic [NUM_WAYS-1:0]    decOut1b;
    logic [19:0]            inpMainTag;
    logic [3:0]             inpHaltTag;

    modport master (
        input  req_valid, req_addr, halt_tags, main_tags, fill_ack,
        output req_ready, rd_index, resp_valid, resp_hit, resp_way,
               fill_req, fill_addr, regWrite, decOut1b, inpMainTag, inpHaltTag
    );

    modport slave (
        output req_valid, req_addr, halt_tags, main_tags, fill_ack,
        input  req_ready, rd_index, resp_valid, resp_hit, resp_way,
               fill_req, fill_addr, regWrite, decOut1b, inpMainTag, inpHaltTag
    );
endinterface

// File: rtl/tag_lookup_ctrl.sv
// Halt-tag filtered lookup controller for an N-way set-associative tag store:
// halt-tag prefilter, main-tag compare, and miss refill with tag write-back.
module tag_lookup_ctrl #(
    parameter int NUM_WAYS = 4,
    parameter int INDEX_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    tag_lookup_ctrl_if.master bus
);
    localparam int WAY_W = $clog2(NUM_WAYS);
    localparam int SETS  = 2 ** INDEX_W;

    typedef enum logic [2:0] {
        IDLE, HALT, CMP, FILL_REQ, FILL_WAIT, TAG_WR, RESP
    } state_t;

    state_t              stateReg, stateNext;
    logic [31:0]         addrReg;
    logic [INDEX_W-1:0]  idxReg;
    logic [NUM_WAYS-1:0] hmaskReg;
    logic [WAY_W-1:0]    victimReg;
    logic                fromPtrReg;
    logic [WAY_W-1:0]    victimPtrReg;
    logic                respHitReg;
    logic [WAY_W-1:0]    respWayReg;
    logic [NUM_WAYS-1:0] validReg [SETS];

    logic [NUM_WAYS-1:0] hmaskNow, hitNow, setValid;
    logic [WAY_W-1:0]    hitWay, freeWay;
    logic                anyHit, anyFree;

    assign setValid = validReg[idxReg];

    for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way
        assign hmaskNow[gi] = setValid[gi] & (bus.halt_tags[4*gi +: 4] == addrReg[15:12]);
        assign hitNow[gi]   = hmaskReg[gi] & (bus.main_tags[20*gi +: 20] == addrReg[31:12]);
    end

    // Priority encoders: lowest hit way, lowest invalid way.
    always_comb begin
        hitWay  = '0;
        freeWay = '0;
        anyHit  = |hitNow;
        anyFree = ~&setValid;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (hitNow[i])    hitWay  = WAY_W'(i);
            if (!setValid[i]) freeWay = WAY_W'(i);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) stateReg <= IDLE;
        else       stateReg <= stateNext;
    end

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:      if (bus.req_valid) stateNext = HALT;
            HALT:      stateNext = (|hmaskNow) ? CMP : FILL_REQ;
            CMP:       stateNext = anyHit ? RESP : FILL_REQ;
            FILL_REQ,
            FILL_WAIT: stateNext = bus.fill_ack ? TAG_WR : FILL_WAIT;
            TAG_WR:    stateNext = RESP;
            RESP:      stateNext = IDLE;
            default:   stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addrReg      <= '0;
            idxReg       <= '0;
            hmaskReg     <= '0;
            victimReg    <= '0;
            fromPtrReg   <= 1'b0;
            victimPtrReg <= '0;
            respHitReg   <= 1'b0;
            respWayReg   <= '0;
            for (int s = 0; s < SETS; s++) validReg[s] <= '0;
        end else begin
            case (stateReg)
                IDLE: if (bus.req_valid) begin
                    addrReg <= bus.req_addr;
                    idxReg  <= bus.req_addr[8 +: INDEX_W];
                end
                HALT: hmaskReg <= hmaskNow;
                CMP: if (anyHit) begin
                    respHitReg <= 1'b1;
                    respWayReg <= hitWay;
                end
                FILL_REQ: begin
                    victimReg  <= anyFree ? freeWay : victimPtrReg;
                    fromPtrReg <= ~anyFree;
                end
                TAG_WR: begin
                    validReg[idxReg][victimReg] <= 1'b1;
                    // Round-robin pointer only advances when it actually chose the victim.
                    if (fromPtrReg)
                        victimPtrReg <= (victimPtrReg == WAY_W'(NUM_WAYS - 1)) ? '0 : victimPtrReg + 1'b1;
                    respHitReg <= 1'b0;
                    respWayReg <= victimReg;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.req_ready  = (stateReg == IDLE);
        bus.resp_valid = (stateReg == RESP);
        bus.fill_req   = (stateReg == FILL_REQ) || (stateReg == FILL_WAIT);
        bus.regWrite   = 1'b0;
        bus.decOut1b   = '0;
        bus.inpMainTag = '0;
        bus.inpHaltTag = '0;
        if (stateReg == TAG_WR) begin
            bus.regWrite   = 1'b1;
            bus.decOut1b   = NUM_WAYS'(1) << victimReg;
            bus.inpMainTag = addrReg[31:12];
            bus.inpHaltTag = addrReg[15:12];
        end
    end

    assign bus.rd_index  = idxReg;
    assign bus.fill_addr = addrReg & 32'hFFFF_FF00;
    assign bus.resp_hit  = respHitReg;
    assign bus.resp_way  = respWayReg;
endmodule

// File: tb/tb_tag_lookup_ctrl.sv
// Directed bench for tag_lookup_ctrl with a behavioural model of the external
// halt/main tag arrays, written whenever the controller strobes regWrite.
module tb_tag_lookup_ctrl;
    localparam int NW = 4;
    localparam int IW = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tag_lookup_ctrl_if #(.NUM_WAYS(NW), .INDEX_W(IW)) ifc ();
    tag_lookup_ctrl #(.NUM_WAYS(NW), .INDEX_W(IW)) dut (.clk(clk), .reset(reset), .bus(ifc));

    logic [3:0]  mH [16][NW];
    logic [19:0] mM [16][NW];
    logic [NW-1:0] shadowV [16];

    for (genvar gi = 0; gi < NW; gi++) begin : g_arr
        assign ifc.halt_tags[4*gi +: 4]   = mH[ifc.rd_index][gi];
        assign ifc.main_tags[20*gi +: 20] = mM[ifc.rd_index][gi];
    end

    int checks = 0;
    int errors = 0;

    // Observations of the last transaction
    logic        rHit, rSaw, rOk, rDup, rTo, rOne;
    logic [1:0]  rWay;
    logic [31:0] rFA;
    logic [3:0]  rDec, rWH;
    logic [19:0] rWT;
    int          rLat, rFC, rWC;

    task automatic run_lookup(input logic [31:0] addr, input int ackDelay);
        logic [3:0] idx;
        rHit = 0; rWay = 0; rLat = 0; rSaw = 0; rFA = 0; rDec = 0; rWT = 0; rWH = 0;
        rFC = 0; rWC = 0; rOk = 1; rDup = 0; rTo = 1; rOne = 0;
        for (int i = 0; i < 50 && !ifc.req_ready; i++) begin @(posedge clk); #1; end
        ifc.req_valid = 1'b1;
        ifc.req_addr  = addr;
        @(posedge clk); #1;
        ifc.req_valid = 1'b0;
        ifc.req_addr  = 32'hDEAD_BEEF;
        rLat = 1;
        for (int i = 0; i < 200; i++) begin
            ifc.fill_ack = 1'b0;
            if (ifc.regWrite) begin
                rWC++;
                rDec = ifc.decOut1b; rWT = ifc.inpMainTag; rWH = ifc.inpHaltTag;
                idx = ifc.rd_index;
                for (int w = 0; w < NW; w++) begin
                    if (ifc.decOut1b[w]) begin
                        for (int w2 = 0; w2 < NW; w2++)
                            if (w2 != w && shadowV[idx][w2] && mM[idx][w2] == ifc.inpMainTag) rDup = 1;
                        mH[idx][w] = ifc.inpHaltTag;
                        mM[idx][w] = ifc.inpMainTag;
                        shadowV[idx][w] = 1'b1;
                    end
                end
            end
            if (ifc.fill_req) begin
                if (!rSaw) begin rSaw = 1; rFA = ifc.fill_addr; end
                else if (ifc.fill_addr !== rFA) rOk = 0;
                if (ifc.req_ready || ifc.regWrite) rOk = 0;
                if (rFC >= ackDelay) ifc.fill_ack = 1'b1;
                rFC++;
            end
            if (ifc.resp_valid) begin
                rHit = ifc.resp_hit; rWay = ifc.resp_way; rTo = 0;
                break;
            end
            @(posedge clk); #1;
            rLat++;
        end
        ifc.fill_ack = 1'b0;
        @(posedge clk); #1;
        rOne = !ifc.resp_valid && ifc.req_ready;
        $display("lookup addr=%h hit=%0b way=%0d lat=%0d fill=%0b fill_addr=%h dec=%b", addr, rHit, rWay, rLat, rSaw, rFA, rDec);
    endtask

    task automatic test_reset();
        ifc.req_valid = 0; ifc.req_addr = 0; ifc.fill_ack = 0;
        for (int s = 0; s < 16; s++) begin
            shadowV[s] = '0;
            for (int w = 0; w < NW; w++) begin mH[s][w] = '0; mM[s][w] = '0; end
        end
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ifc.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ifc.req_ready); end
        checks++; if ({ifc.resp_valid, ifc.fill_req, ifc.regWrite} !== 3'b000) begin errors++; $display("FAIL reset_strobes got %b want 000", {ifc.resp_valid, ifc.fill_req, ifc.regWrite}); end
        checks++; if (ifc.decOut1b !== 4'b0 || ifc.rd_index !== 4'h0) begin errors++; $display("FAIL reset_dec_idx got %b/%h want 0000/0", ifc.decOut1b, ifc.rd_index); end
        checks++; if (ifc.fill_addr !== 32'h0 || ifc.inpMainTag !== 20'h0 || ifc.inpHaltTag !== 4'h0) begin errors++; $display("FAIL reset_data got %h/%h/%h want 0", ifc.fill_addr, ifc.inpMainTag, ifc.inpHaltTag); end
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (ifc.req_ready !== 1'b1 || ifc.resp_hit !== 1'b0 || ifc.resp_way !== 2'd0) begin errors++; $display("FAIL reset_release got ready=%b hit=%b way=%0d want 1/0/0", ifc.req_ready, ifc.resp_hit, ifc.resp_way); end
    endtask

    task automatic test_early_miss();
        run_lookup(32'h1234_5A00, 0);
        checks++; if (rTo !== 1'b0) begin errors++; $display("FAIL t1_timeout got %b want 0", rTo); end
        checks++; if (rHit !== 1'b0 || rWay !== 2'd0) begin errors++; $display("FAIL t1_resp got hit=%b way=%0d want 0/0", rHit, rWay); end
        checks++; if (rSaw !== 1'b1 || rFA !== 32'h1234_5A00) begin errors++; $display("FAIL t1_fill got %b/%h want 1/12345a00", rSaw, rFA); end
        checks++; if (rDec !== 4'b0001 || rWT !== 20'h12345 || rWH !== 4'h5) begin errors++; $display("FAIL t1_write got %b/%h/%h want 0001/12345/5", rDec, rWT, rWH); end
        checks++; if (rLat !== 4 || rWC !== 1) begin errors++; $display("FAIL t1_latency got lat=%0d wr=%0d want 4/1", rLat, rWC); end
        checks++; if (rOne !== 1'b1 || rOk !== 1'b1) begin errors++; $display("FAIL t1_oneshot got %b/%b want 1/1", rOne, rOk); end
    endtask

    task automatic test_hit();
        run_lookup(32'h1234_5A00, 0);
        checks++; if (rTo !== 1'b0 || rHit !== 1'b1 || rWay !== 2'd0) begin errors++; $display("FAIL t2_resp got to=%b hit=%b way=%0d want 0/1/0", rTo, rHit, rWay); end
        checks++; if (rLat !== 3) begin errors++; $display("FAIL t2_latency got %0d want 3", rLat); end
        checks++; if (rSaw !== 1'b0 || rWC !== 0) begin errors++; $display("FAIL t2_nofill got fill=%b wr=%0d want 0/0", rSaw, rWC); end
    endtask

    task automatic test_halt_alias();
        run_lookup(32'h0000_5A00, 0);
        checks++; if (rTo !== 1'b0 || rHit !== 1'b0 || rWay !== 2'd1) begin errors++; $display("FAIL t3_resp got to=%b hit=%b way=%0d want 0/0/1", rTo, rHit, rWay); end
        checks++; if (rDec !== 4'b0010 || rWT !== 20'h00005) begin errors++; $display("FAIL t3_write got %b/%h want 0010/00005", rDec, rWT); end
        checks++; if (rLat !== 5) begin errors++; $display("FAIL t3_latency got %0d want 5", rLat); end
    endtask

    task automatic test_victim_rotation();
        logic [19:0] tags [7];
        logic [1:0]  ways [7];
        tags = '{20'hAAAA1, 20'hAAAA2, 20'hBBBB1, 20'hBBBB2, 20'hBBBB3, 20'hBBBB4, 20'hBBBB5};
        ways = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        for (int k = 0; k < 7; k++) begin
            run_lookup({tags[k], 12'hA00}, 0);
            checks++;
            if (rTo !== 1'b0 || rHit !== 1'b0 || rWay !== ways[k] || rDec !== (4'b0001 << ways[k]) || rDup !== 1'b0) begin
                errors++;
                $display("FAIL t4_victim%0d got to=%b hit=%b way=%0d dec=%b dup=%b want 0/0/%0d", k, rTo, rHit, rWay, rDec, rDup, ways[k]);
            end
        end
        run_lookup(32'hBBBB_2A00, 0);
        checks++; if (rTo !== 1'b0 || rHit !== 1'b1 || rWay !== 2'd1) begin errors++; $display("FAIL t4_rehit got to=%b hit=%b way=%0d want 0/1/1", rTo, rHit, rWay); end
    endtask

    task automatic test_fill_stall();
        run_lookup(32'hCAFE_337C, 10);
        checks++; if (rTo !== 1'b0 || rHit !== 1'b0 || rWay !== 2'd0) begin errors++; $display("FAIL t5_resp got to=%b hit=%b way=%0d want 0/0/0", rTo, rHit, rWay); end
        checks++; if (rFA !== 32'hCAFE_3300) begin errors++; $display("FAIL t5_fill_addr got %h want cafe3300", rFA); end
        checks++; if (rFC !== 11 || rOk !== 1'b1) begin errors++; $display("FAIL t5_hold got cycles=%0d stable=%b want 11/1", rFC, rOk); end
        checks++; if (rDec !== 4'b0001 || rWT !== 20'hCAFE3 || rWH !== 4'h3 || rWC !== 1) begin errors++; $display("FAIL t5_write got %b/%h/%h/%0d want 0001/cafe3/3/1", rDec, rWT, rWH, rWC); end
        checks++; if (rLat !== 14) begin errors++; $display("FAIL t5_latency got %0d want 14", rLat); end
    endtask

    task automatic test_reset_mid_fill();
        logic seen;
        seen = 0;
        ifc.req_valid = 1'b1;
        ifc.req_addr  = 32'h7777_7700;
        @(posedge clk); #1;
        ifc.req_valid = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (ifc.fill_req) seen = 1;
            else begin @(posedge clk); #1; end
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL t6_fill_seen got %b want 1", seen); end
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checks++; if (ifc.fill_req !== 1'b0 || ifc.regWrite !== 1'b0 || ifc.req_ready !== 1'b1) begin errors++; $display("FAIL t6_async got fill=%b wr=%b ready=%b want 0/0/1", ifc.fill_req, ifc.regWrite, ifc.req_ready); end
        for (int s = 0; s < 16; s++) shadowV[s] = '0;
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        run_lookup(32'hBBBB_2A00, 0);
        checks++; if (rTo !== 1'b0 || rHit !== 1'b0 || rWay !== 2'd0) begin errors++; $display("FAIL t6_miss got to=%b hit=%b way=%0d want 0/0/0", rTo, rHit, rWay); end
        checks++; if (rSaw !== 1'b1 || rLat !== 4) begin errors++; $display("FAIL t6_refill got fill=%b lat=%0d want 1/4", rSaw, rLat); end
    endtask

    initial begin
        test_reset();
        test_early_miss();
        test_hit();
        test_halt_alias();
        test_victim_rotation();
        test_fill_stall();
        test_reset_mid_fill();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
